// File: rtl/secure_sib.sv
// Key-protected SIB: opens a hidden IJTAG segment only after the unlock key is shifted in and updated.
// Latency: ToSegSel/Locked/Alarm update on the edge sampling UpdateEn; SO/ToSegSI are register outputs.
// Backpressure: none, strobe driven. Optional idle auto-relock under `define SECURE_SIB_RELOCK_EN.
module secure_sib #(
    parameter int              KEY_W     = 8,
    parameter logic [KEY_W-1:0] KEY      = KEY_W'(8'hA5),
    parameter int              MAX_TRIES = 3
`ifdef SECURE_SIB_RELOCK_EN
    ,
    parameter int              RELOCK_CYCLES = 1024
`endif
) (
    input  logic CLK,
    input  logic Rst,
    input  logic SI,
    input  logic SelectIn,
    input  logic CaptureEn,
    input  logic ShiftEn,
    input  logic UpdateEn,
    input  logic FromSegSO,
    output logic SO,
    output logic ToSegSI,
    output logic ToSegSel,
    output logic Locked,
    output logic Alarm
);

    typedef enum logic [1:0] {
        ST_LOCKED   = 2'd0,
        ST_UNLOCKED = 2'd1,
        ST_BLOCKED  = 2'd2
    } state_t;

    localparam logic [4:0] MaxTries = 5'(MAX_TRIES);

    state_t           state, state_nxt;
    logic [KEY_W-1:0] key_sr, key_sr_nxt;
    logic             sib_sr, sib_sr_nxt;
    logic             sib_upd, sib_upd_nxt;
    logic [3:0]       tries, tries_nxt;
    logic [4:0]       tries_inc;
    logic             do_capture, do_shift, do_update;

    // One action per cycle: Capture beats Shift beats Update.
    assign do_capture = SelectIn & CaptureEn;
    assign do_shift   = SelectIn & ShiftEn & ~CaptureEn;
    assign do_update  = SelectIn & UpdateEn & ~CaptureEn & ~ShiftEn;
    assign tries_inc  = {1'b0, tries} + 5'd1;

`ifdef SECURE_SIB_RELOCK_EN
    localparam int RelockW = $clog2(RELOCK_CYCLES + 1);
    logic [RelockW-1:0] relock_cnt, relock_cnt_nxt;
`endif

    always_comb begin
        state_nxt   = state;
        key_sr_nxt  = key_sr;
        sib_sr_nxt  = sib_sr;
        sib_upd_nxt = sib_upd;
        tries_nxt   = tries;
`ifdef SECURE_SIB_RELOCK_EN
        relock_cnt_nxt = '0;
`endif
        if (do_capture) begin
            key_sr_nxt = '0;
            sib_sr_nxt = sib_upd;
        end else if (do_shift) begin
            key_sr_nxt = {SI, key_sr[KEY_W-1:1]};
            sib_sr_nxt = sib_upd ? FromSegSO : key_sr[0];
        end else if (do_update) begin
            case (state)
                ST_LOCKED: begin
                    if (key_sr == KEY) begin
                        state_nxt   = ST_UNLOCKED;
                        sib_upd_nxt = sib_sr;
                        tries_nxt   = 4'd0;
                    end else begin
                        sib_upd_nxt = 1'b0;
                        if (tries != 4'hF) begin
                            tries_nxt = tries_inc[3:0];
                        end
                        if (tries_inc == MaxTries) begin
                            state_nxt = ST_BLOCKED;
                        end
                    end
                end
                ST_UNLOCKED: begin
                    // Key is not re-checked while open; writing 0 closes and relocks.
                    sib_upd_nxt = sib_sr;
                    if (!sib_sr) begin
                        state_nxt = ST_LOCKED;
                    end
                end
                ST_BLOCKED: begin
                    sib_upd_nxt = 1'b0;
                end
                default: begin
                    state_nxt   = ST_LOCKED;
                    sib_upd_nxt = 1'b0;
                end
            endcase
        end
`ifdef SECURE_SIB_RELOCK_EN
        if (state == ST_UNLOCKED && !(do_capture || do_shift || do_update)) begin
            if (relock_cnt == RelockW'(RELOCK_CYCLES - 1)) begin
                state_nxt   = ST_LOCKED;
                sib_upd_nxt = 1'b0;
            end else begin
                relock_cnt_nxt = relock_cnt + RelockW'(1);
            end
        end
`endif
        if (state == ST_BLOCKED) begin
            sib_upd_nxt = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (Rst) begin
            state   <= ST_LOCKED;
            key_sr  <= '0;
            sib_sr  <= 1'b0;
            sib_upd <= 1'b0;
            tries   <= 4'd0;
        end else begin
            state   <= state_nxt;
            key_sr  <= key_sr_nxt;
            sib_sr  <= sib_sr_nxt;
            sib_upd <= sib_upd_nxt;
            tries   <= tries_nxt;
        end
    end

`ifdef SECURE_SIB_RELOCK_EN
    always_ff @(posedge CLK) begin
        if (Rst) begin
            relock_cnt <= '0;
        end else begin
            relock_cnt <= relock_cnt_nxt;
        end
    end
`endif

    assign SO       = sib_sr;
    assign ToSegSI  = key_sr[0];
    assign ToSegSel = sib_upd;
    assign Locked   = (state != ST_UNLOCKED);
    assign Alarm    = (state == ST_BLOCKED);

endmodule
